// File: rtl/axis_dispatch4_pkg.sv
// Shared definitions for the axis_dispatch4 one-to-four packet dispatcher:
// route modes, route state encoding and state/index conversion helpers.
package axis_dispatch4_pkg;

    localparam int ROUTE_TDEST = 0;
    localparam int ROUTE_RR    = 1;

    // MSB marks an open packet, low two bits carry the locked output.
    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        LOCK0 = 3'b100,
        LOCK1 = 3'b101,
        LOCK2 = 3'b110,
        LOCK3 = 3'b111
    } route_state_e;

    function automatic route_state_e lock_of(input logic [1:0] k);
        route_state_e st;
        case (k)
            2'd0:    st = LOCK0;
            2'd1:    st = LOCK1;
            2'd2:    st = LOCK2;
            2'd3:    st = LOCK3;
            default: st = IDLE;
        endcase
        return st;
    endfunction

    function automatic logic [1:0] lock_target(input route_state_e st);
        logic [1:0] k;
        case (st)
            LOCK0:   k = 2'd0;
            LOCK1:   k = 2'd1;
            LOCK2:   k = 2'd2;
            LOCK3:   k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/axis_dispatch4_skid.sv
// Two-entry AXI-Stream register slice. Input-side ready depends only on the
// registered occupancy, so there is no combinational path from out_ready.
module axis_skid
    import axis_dispatch4_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Pointer and occupancy tracking; push and pop together leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Payload storage; contents are meaningless while the entry is empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

endmodule

// File: rtl/axis_dispatch4.sv
// One-to-four AXI-Stream packet dispatcher: a route is picked on a packet's
// first flit (by TDEST or round-robin) and held until its TLAST flit.
module axis_dispatch4
    import axis_dispatch4_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PIPE_STAGE = 1,
    parameter int ROUTE_MODE = ROUTE_TDEST,
    parameter int TLAST_ARB  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    input  logic                  s_TLAST,
    input  logic [1:0]            s_TDEST,
    output logic [DATA_WIDTH-1:0] o0_TDATA,
    output logic                  o0_TVALID,
    input  logic                  o0_TREADY,
    output logic                  o0_TLAST,
    output logic [DATA_WIDTH-1:0] o1_TDATA,
    output logic                  o1_TVALID,
    input  logic                  o1_TREADY,
    output logic                  o1_TLAST,
    output logic [DATA_WIDTH-1:0] o2_TDATA,
    output logic                  o2_TVALID,
    input  logic                  o2_TREADY,
    output logic                  o2_TLAST,
    output logic [DATA_WIDTH-1:0] o3_TDATA,
    output logic                  o3_TVALID,
    input  logic                  o3_TREADY,
    output logic                  o3_TLAST
);

    route_state_e        state_r;
    route_state_e        state_nxt_s;
    logic [1:0]          rr_ptr_r;
    logic [1:0]          rr_ptr_nxt_s;
    logic [1:0]          sel_s;
    logic [3:0]          sel_onehot_s;
    logic                fire_s;
    logic [3:0]          out_ready_s;
    logic [3:0]          slice_in_valid_s;
    logic [3:0]          slice_in_ready_s;
    logic [3:0]          slice_out_valid_s;
    logic [DATA_WIDTH:0] in_pl_s;
    logic [DATA_WIDTH:0] out_pl_s [4];

    assign out_ready_s      = {o3_TREADY, o2_TREADY, o1_TREADY, o0_TREADY};
    assign in_pl_s          = {s_TLAST, s_TDATA};
    assign sel_onehot_s     = 4'b0001 << sel_s;
    assign slice_in_valid_s = sel_onehot_s & {4{s_TVALID & rst}};
    assign s_TREADY         = rst & slice_in_ready_s[sel_s];
    assign fire_s           = s_TVALID & s_TREADY;

    // Current route: new packets follow TDEST or the pointer, open packets stay put.
    always_comb begin
        sel_s = 2'd0;
        case (state_r)
            IDLE:    sel_s = (ROUTE_MODE == ROUTE_RR) ? rr_ptr_r : s_TDEST;
            LOCK0, LOCK1, LOCK2, LOCK3:
                     sel_s = lock_target(state_r);
            default: sel_s = 2'd0;
        endcase
    end

    // Next route state and round-robin pointer, advanced only by fired flits.
    always_comb begin
        state_nxt_s  = state_r;
        rr_ptr_nxt_s = rr_ptr_r;
        if (fire_s) begin
            if (s_TLAST) begin
                state_nxt_s  = IDLE;
                rr_ptr_nxt_s = rr_ptr_r + 2'd1;
            end else if ((state_r == IDLE) && (TLAST_ARB != 0)) begin
                state_nxt_s = lock_of(sel_s);
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Route state and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= IDLE;
            rr_ptr_r <= 2'd0;
        end else begin
            state_r  <= state_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_out
        if (PIPE_STAGE != 0) begin : g_skid
            axis_skid #(
                .WIDTH(DATA_WIDTH + 1)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .in_data  (in_pl_s),
                .in_valid (slice_in_valid_s[n]),
                .in_ready (slice_in_ready_s[n]),
                .out_data (out_pl_s[n]),
                .out_valid(slice_out_valid_s[n]),
                .out_ready(out_ready_s[n])
            );
        end else begin : g_bypass
            assign slice_in_ready_s[n]  = out_ready_s[n];
            assign slice_out_valid_s[n] = slice_in_valid_s[n];
            assign out_pl_s[n]          = in_pl_s;
        end
    end

    // Valids are forced low while reset is held, even before the first reset edge.
    assign o0_TVALID = slice_out_valid_s[0] & rst;
    assign o1_TVALID = slice_out_valid_s[1] & rst;
    assign o2_TVALID = slice_out_valid_s[2] & rst;
    assign o3_TVALID = slice_out_valid_s[3] & rst;
    assign o0_TDATA  = out_pl_s[0][DATA_WIDTH-1:0];
    assign o1_TDATA  = out_pl_s[1][DATA_WIDTH-1:0];
    assign o2_TDATA  = out_pl_s[2][DATA_WIDTH-1:0];
    assign o3_TDATA  = out_pl_s[3][DATA_WIDTH-1:0];
    assign o0_TLAST  = out_pl_s[0][DATA_WIDTH];
    assign o1_TLAST  = out_pl_s[1][DATA_WIDTH];
    assign o2_TLAST  = out_pl_s[2][DATA_WIDTH];
    assign o3_TLAST  = out_pl_s[3][DATA_WIDTH];

endmodule
